// File: rtl/tri_des_sched.sv
// tri_des_sched: sequences three passes of a shared DES core to perform 3DES EDE/DED,
// with a per-pass timeout and a valid/ready result handshake.
module tri_des_sched #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:63] data_in,
    input  logic [0:63] key1,
    input  logic [0:63] key2,
    input  logic [0:63] key3,
    input  logic        mode,
    output logic        core_start,
    output logic        core_decrypt,
    output logic [0:63] core_data,
    output logic [0:63] core_key,
    input  logic        core_done,
    input  logic [0:63] core_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:63] data_out,
    output logic        out_err
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 2);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, OUT} state_t;
    state_t        state;
    logic [1:0]    pass;
    logic [TW-1:0] tcnt;
    logic [0:63]   work, k1, k2, k3;
    logic          md;
    // Operands come straight from job registers, so they stay fixed for the whole pass.
    assign in_ready     = state == IDLE;
    assign core_data    = work;
    assign core_decrypt = md ^ (pass == 2'd1);
    assign core_key     = (pass == 2'd1) ? k2 : (((pass == 2'd0) ^ md) ? k1 : k3);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pass       <= 2'd0;
            tcnt       <= '0;
            work       <= '0;
            k1         <= '0;
            k2         <= '0;
            k3         <= '0;
            md         <= 1'b0;
            core_start <= 1'b0;
            out_valid  <= 1'b0;
            out_err    <= 1'b0;
            data_out   <= '0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    work       <= data_in;
                    k1         <= key1;
                    k2         <= key2;
                    k3         <= key3;
                    md         <= mode;
                    pass       <= 2'd0;
                    tcnt       <= '0;
                    core_start <= 1'b1;
                    state      <= LAUNCH;
                end
                LAUNCH: state <= WAIT;
                WAIT: if (core_done) begin
                    work <= core_result;
                    tcnt <= '0;
                    if (pass == 2'd2) begin
                        out_valid <= 1'b1;
                        out_err   <= 1'b0;
                        data_out  <= core_result;
                        state     <= OUT;
                    end else begin
                        pass       <= pass + 2'd1;
                        core_start <= 1'b1;
                        state      <= LAUNCH;
                    end
                end else begin
                    // Abort when the count steps onto TIMEOUT-1; a coincident done wins above.
                    tcnt <= tcnt + TW'(1);
                    if (tcnt == TLAST) begin
                        out_valid <= 1'b1;
                        out_err   <= 1'b1;
                        data_out  <= '0;
                        state     <= OUT;
                    end
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tri_des_sched.sv
// tb_tri_des_sched: directed checks of tri_des_sched against a behavioural DES/XOR core
// with programmable latency.
module tb_tri_des_sched;
    localparam int TIMEOUT = 64;
    localparam logic [0:63] K = 64'h133457799BBCDFF1;
    localparam int IP[64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                              57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    localparam int FP[64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                              36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
    localparam int ET[48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                              16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    localparam int P[32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam int PC1[56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                               63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    localparam int PC2[48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                               41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int SH[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int SB[512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, mode = 1'b0, out_ready = 1'b1, core_done = 1'b0;
    logic        in_ready, core_start, core_decrypt, out_valid, out_err;
    logic [0:63] data_in = '0, key1 = '0, key2 = '0, key3 = '0, core_result = '0;
    logic [0:63] core_data, core_key, data_out, res;
    int          checks = 0, failures = 0, lat = 3, cnt = 0, starts = 0;
    bit          hang = 1'b0, use_des = 1'b0, inject = 1'b0;
    logic [0:128] log_q[$];

    tri_des_sched #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .key1(key1), .key2(key2), .key3(key3), .mode(mode), .core_start(core_start),
        .core_decrypt(core_decrypt), .core_data(core_data), .core_key(core_key),
        .core_done(core_done), .core_result(core_result), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .out_err(out_err)
    );

    always #5 clk = ~clk;

    function automatic logic [0:63] des(input logic [0:63] d, input logic [0:63] k, input logic dec);
        logic [0:55] cd;
        logic [0:47] ks[16];
        logic [0:63] x, y;
        logic [0:31] l, r, f, s, t;
        logic [0:47] e;
        logic [0:5]  b;
        int          v;
        for (int i = 0; i < 56; i++) cd[i] = k[PC1[i]-1];
        for (int n = 0; n < 16; n++) begin
            for (int j = 0; j < SH[n]; j++) cd = {cd[1:27], cd[0], cd[29:55], cd[28]};
            for (int i = 0; i < 48; i++) ks[n][i] = cd[PC2[i]-1];
        end
        for (int i = 0; i < 64; i++) x[i] = d[IP[i]-1];
        l = x[0:31];
        r = x[32:63];
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 48; i++) e[i] = r[ET[i]-1];
            e = e ^ ks[dec ? 15 - n : n];
            for (int j = 0; j < 8; j++) begin
                b = e[j*6 +: 6];
                v = SB[j*64 + 32*int'(b[0]) + 16*int'(b[5]) + int'(b[1:4])];
                s[j*4 +: 4] = v[3:0];
            end
            for (int i = 0; i < 32; i++) f[i] = s[P[i]-1];
            t = r;
            r = l ^ f;
            l = t;
        end
        y = {r, l};
        for (int i = 0; i < 64; i++) x[i] = y[FP[i]-1];
        return x;
    endfunction

    // Core model: answers core_start after lat cycles unless hung; inject forces a stray done.
    always @(posedge clk) begin
        core_done <= inject;
        if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                core_done   <= 1'b1;
                core_result <= res;
            end
        end
        if (core_start) begin
            starts <= starts + 1;
            log_q.push_back({core_decrypt, core_key, core_data});
            if (!hang) begin
                if (lat == 1) begin
                    core_done   <= 1'b1;
                    core_result <= use_des ? des(core_data, core_key, core_decrypt) : core_data ^ core_key;
                end else begin
                    cnt <= lat - 1;
                    res <= use_des ? des(core_data, core_key, core_decrypt) : core_data ^ core_key;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic rst_chk(input string tag);
        check({tag, ".ctl"}, 64'({core_start, core_decrypt, out_valid, out_err, in_ready}), 64'b00001);
        check({tag, ".core_data"}, core_data, 64'h0);
        check({tag, ".core_key"}, core_key, 64'h0);
        check({tag, ".data_out"}, data_out, 64'h0);
    endtask

    // Starts on the negedge just after the accepting edge; cycle 1 is the LAUNCH cycle.
    task automatic wait_out(input string tag, input logic [0:63] exp, input logic eerr, input int ecyc);
        int n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".cyc"}, 64'(n + 1), 64'(ecyc));
        check({tag, ".data"}, data_out, exp);
        check({tag, ".err"}, 64'(out_err), 64'(eerr));
    endtask

    task automatic job(input string tag, input logic [0:63] d, a, b, c, input logic m,
                       input logic [0:63] exp, input logic eerr, input int ecyc);
        @(negedge clk);
        data_in = d; key1 = a; key2 = b; key3 = c; mode = m; in_valid = 1'b1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        data_in = {$urandom, $urandom}; key1 = {$urandom, $urandom};
        key2 = {$urandom, $urandom}; key3 = {$urandom, $urandom}; mode = ~m;
        wait_out(tag, exp, eerr, ecyc);
        @(negedge clk);
        check({tag, ".idle"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    task automatic chk_log(input string tag, input logic m, input logic [0:63] d, a, b, c);
        logic [0:63]  kk[3];
        logic [0:63]  x;
        logic [0:128] e;
        kk = m ? '{c, b, a} : '{a, b, c};
        x = d;
        check({tag, ".starts"}, 64'(log_q.size()), 64'd3);
        for (int i = 0; i < 3 && i < log_q.size(); i++) begin
            e = log_q[i];
            check($sformatf("%s.dec%0d", tag, i), 64'(e[0]), 64'(m ? (i != 1) : (i == 1)));
            check($sformatf("%s.key%0d", tag, i), e[1:64], kk[i]);
            check($sformatf("%s.dat%0d", tag, i), e[65:128], x);
            x = x ^ kk[i];
        end
    endtask

    initial begin
        int  s0;
        bit  bad;
        repeat (3) @(negedge clk);
        rst_chk("reset");
        rst = 1'b1;
        @(negedge clk);

        log_q.delete();
        job("xor_enc", 64'h0, 64'h1, 64'h2, 64'h4, 1'b0, 64'h7, 1'b0, 13);
        chk_log("xor_enc", 1'b0, 64'h0, 64'h1, 64'h2, 64'h4);
        log_q.delete();
        job("xor_dec", 64'h0, 64'h1, 64'h2, 64'h4, 1'b1, 64'h7, 1'b0, 13);
        chk_log("xor_dec", 1'b1, 64'h0, 64'h1, 64'h2, 64'h4);
        lat = 1;
        job("xor_l1", 64'hF0, 64'h1, 64'h2, 64'h4, 1'b0, 64'hF7, 1'b0, 7);

        use_des = 1'b1; lat = 2;
        job("des_enc", 64'h0123456789ABCDEF, K, K, K, 1'b0, 64'h85E813540F0AB405, 1'b0, 10);
        job("des_dec", 64'h85E813540F0AB405, K, K, K, 1'b1, 64'h0123456789ABCDEF, 1'b0, 10);

        use_des = 1'b0; lat = 3; hang = 1'b1;
        job("tmo", 64'h5, 64'h1, 64'h2, 64'h4, 1'b0, 64'h0, 1'b1, 65);
        hang = 1'b0;
        job("after_tmo", 64'h5, 64'h1, 64'h2, 64'h4, 1'b0, 64'h2, 1'b0, 13);

        @(negedge clk); inject = 1'b1;
        @(negedge clk); inject = 1'b0;
        @(negedge clk);
        check("idle_done", 64'({in_ready, core_start, out_valid}), 64'b100);
        lat = 63;
        job("coinc", 64'h8, 64'h1, 64'h2, 64'h4, 1'b0, 64'hF, 1'b0, 193);
        lat = 64;
        job("late_tmo", 64'h8, 64'h1, 64'h2, 64'h4, 1'b0, 64'h0, 1'b1, 65);

        lat = 3; out_ready = 1'b0;
        @(negedge clk);
        data_in = 64'h9; key1 = 64'h1; key2 = 64'h2; key3 = 64'h4; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_in = 64'hAA;
        wait_out("bp", 64'hE, 1'b0, 13);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({out_valid, in_ready, core_start, out_err} !== 4'b1000 || data_out !== 64'hE) bad = 1'b1;
        end
        check("bp.hold", 64'(bad), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp.release", 64'({out_valid, in_ready}), 64'b01);
        @(negedge clk);
        check("bp.accept", 64'({in_ready, core_start}), 64'b01);
        in_valid = 1'b0;
        wait_out("bp2", 64'hAD, 1'b0, 13);
        @(negedge clk);

        @(negedge clk);
        data_in = 64'h3; key1 = 64'h1; key2 = 64'h2; key3 = 64'h4; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        rst_chk("midrst");
        s0 = starts;
        @(negedge clk);
        rst = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid || core_start || !in_ready) bad = 1'b1;
        end
        check("post_rst.quiet", 64'(bad), 64'd0);
        check("post_rst.starts", 64'(starts - s0), 64'd0);
        rst_chk("post_rst");
        job("fresh", 64'h3, 64'h1, 64'h2, 64'h4, 1'b0, 64'h4, 1'b0, 13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/tri_des_sched.md
TRI_DES_SCHED -- requirements
Module: tri_des_sched

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 64, giving the maximum cycles to wait for core_done per pass before aborting.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid  input  1  request valid.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a request (high only in IDLE).
REQ-006 The block SHALL have port data_in  input  [0:63]  plaintext or ciphertext block.
REQ-007 The block SHALL have ports key1, key2, key3  input  [0:63] each  3DES keys, with parity bits ignored.
REQ-008 The block SHALL have port mode  input  1  0 = encrypt (EDE), 1 = decrypt (DED).
REQ-009 The block SHALL have port core_start  output  1  one-cycle start pulse to the shared DES core.
REQ-010 The block SHALL have port core_decrypt  output  1  direction for the current pass.
REQ-011 The block SHALL have ports core_data and core_key  output  [0:63] each  operands for the current pass.
REQ-012 The block SHALL have port core_done  input  1  one-cycle pulse from the core when core_result is valid.
REQ-013 The block SHALL have port core_result  input  [0:63]  core output.
REQ-014 The block SHALL have port out_valid  output  1  result valid.
REQ-015 The block SHALL have port out_ready  input  1  consumer accepts the result.
REQ-016 The block SHALL have ports data_out  output  [0:63]  and out_err  output  1  result and timeout flag.

Function
REQ-017 The FSM SHALL have states IDLE, LAUNCH, WAIT and OUT, and a 2-bit pass counter with values 0..2.
REQ-018 In IDLE with in_valid=1, the block SHALL latch data_in, key1-3 and mode into a work register and key/mode registers, clear pass to 0 and the timeout counter to 0, and go to LAUNCH.
REQ-019 Input ports SHALL be ignored outside the accepting cycle; changes during a job SHALL NOT affect that job.
REQ-020 With mode=0 the pass sequence SHALL be: pass0 encrypt key1; pass1 decrypt key2; pass2 encrypt key3.
REQ-021 With mode=1 the pass sequence SHALL be: pass0 decrypt key3; pass1 encrypt key2; pass2 decrypt key1.
REQ-022 In LAUNCH, core_start SHALL be 1 for exactly one cycle, core_data SHALL equal the work register, and core_key/core_decrypt SHALL be per REQ-020/021; the next state SHALL be WAIT.
REQ-023 core_data, core_key and core_decrypt SHALL be held stable from LAUNCH until the cycle core_done is sampled.
REQ-024 In WAIT, on core_done=1 the block SHALL load core_result into the work register, clear the timeout counter, and then:
- if pass<2: increment pass and go to LAUNCH;
- if pass=2: go to OUT with out_err=0.
REQ-025 In WAIT, the timeout counter SHALL increment each cycle without core_done; when it reaches TIMEOUT-1 without core_done, the block SHALL set out_err=1, drive data_out=64'h0 and go to OUT.
REQ-026 core_done in any state other than WAIT SHALL be ignored.
REQ-027 core_done arriving in the same cycle as the timeout SHALL win: it is processed per REQ-024.
REQ-028 In OUT, out_valid SHALL be 1 and data_out/out_err SHALL be held stable until out_ready=1; the cycle after the handshake the state SHALL be IDLE.
REQ-029 in_ready SHALL be 0 in OUT, so a request that coincides with the output handshake is accepted no earlier than the next cycle.
REQ-030 Latency: with a core that pulses core_done L cycles after core_start (L>=1), out_valid SHALL rise exactly 3*(L+1)+1 cycles after the accepting edge; throughput SHALL be one job per 3*(L+1)+2 cycles with out_ready held at 1.
REQ-031 data_out SHALL equal the work register after pass 2.

Reset
REQ-032 While rst=0, the block SHALL be in state IDLE with pass=0, timeout counter=0, work register=0, core_start=0, core_decrypt=0, core_data=0, core_key=0, out_valid=0, out_err=0 and data_out=0; in_ready SHALL be 1.
REQ-033 Reset asserted mid-job SHALL abandon the job immediately with no core_start pulse issued afterwards.
REQ-034 A core_done arriving after reset release SHALL be ignored per REQ-026.

Verification
REQ-035 Stub core with L=3 and result = data XOR key; mode=0, data 64'h0, keys 64'h1, 64'h2, 64'h4 -> data_out 64'h7, out_err=0, out_valid at cycle 13 after accept, exactly three core_start pulses with core_decrypt 0, 1, 0.
REQ-036 Real DES core model; key1=key2=key3=64'h133457799BBCDFF1, data 64'h0123456789ABCDEF, mode=0 -> 64'h85E813540F0AB405; feed that result back with mode=1 -> 64'h0123456789ABCDEF, with pass keys in order key3, key2, key1.
REQ-037 Core never asserts core_done, TIMEOUT=64 -> out_valid with out_err=1 and data_out=0 64 cycles after LAUNCH; the next job completes normally.
REQ-038 Hold out_ready=0 for 10 cycles -> data_out/out_valid stable, in_ready=0, and in_valid is ignored throughout; after out_ready=1 -> IDLE and the next request is accepted the following cycle.
REQ-039 Assert rst=0 in WAIT of pass 1, then release and issue a late core_done -> no out_valid, no core_start, all outputs at reset values; a fresh job afterwards gives the correct result.
REQ-040 Spurious core_done in IDLE, and core_done coincident with the timeout cycle -> the IDLE pulse is ignored and the coincident pulse is processed as success.
